// File: rtl/ysyx_220053_lsu_pkg.sv
// Shared definitions for the load/store unit: memop encodings, FSM states,
// access sizes with their byte-lane masks, and the alignment rule.
package ysyx_220053_lsu_pkg;

    localparam logic [2:0] MEMOP_LW      = 3'b000;
    localparam logic [2:0] MEMOP_LB      = 3'b001;
    localparam logic [2:0] MEMOP_LH      = 3'b010;
    localparam logic [2:0] MEMOP_LD      = 3'b011;
    localparam logic [2:0] MEMOP_LWU     = 3'b100;
    localparam logic [2:0] MEMOP_LBU     = 3'b101;
    localparam logic [2:0] MEMOP_LHU     = 3'b110;
    localparam logic [2:0] MEMOP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SZ_W = 2'b00,
        SZ_B = 2'b01,
        SZ_H = 2'b10,
        SZ_D = 2'b11
    } size_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic size_e op_size(input logic [2:0] op);
        case (op)
            MEMOP_LB, MEMOP_LBU:     return SZ_B;
            MEMOP_LH, MEMOP_LHU:     return SZ_H;
            MEMOP_LW, MEMOP_LWU:     return SZ_W;
            MEMOP_LD, MEMOP_ILLEGAL: return SZ_D;
            default:                 return SZ_D;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input size_e sz);
        case (sz)
            SZ_B:    return MASK_B;
            SZ_H:    return MASK_H;
            SZ_W:    return MASK_W;
            default: return MASK_D;
        endcase
    endfunction

    // Bytes can sit anywhere; wider accesses must be naturally aligned.
    function automatic logic misaligned(input size_e sz, input logic [2:0] off);
        case (sz)
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            SZ_D:    return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_220053_lsu_align.sv
// Combinational lane logic: doubleword address, store shift and byte mask,
// load shift plus sign/zero extension, and the request legality check.
module ysyx_220053_lsu_align
    import ysyx_220053_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      chk_op_i,
    input  logic [2:0]      chk_off_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [7:0]      mem_wmask_o,
    output logic [XLEN-1:0] load_data_o,
    output logic            chk_err_o
);

    size_e           size;
    logic [5:0]      shamt;
    logic [XLEN-1:0] wsized;
    logic [XLEN-1:0] rshift;
    logic            sext;

    // NOTE: every output gets a value before the case so no path can infer a latch.
    always_comb begin
        size        = op_size(op_i);
        shamt       = {addr_i[2:0], 3'b000};
        sext        = ~op_i[2];
        wsized      = wdata_i;
        load_data_o = '0;

        case (size)
            SZ_B:    wsized = XLEN'(wdata_i[7:0]);
            SZ_H:    wsized = XLEN'(wdata_i[15:0]);
            SZ_W:    wsized = XLEN'(wdata_i[31:0]);
            default: wsized = wdata_i;
        endcase

        rshift = rdata_i >> shamt;
        case (size)
            SZ_B:    load_data_o = {{(XLEN-8){sext & rshift[7]}}, rshift[7:0]};
            SZ_H:    load_data_o = {{(XLEN-16){sext & rshift[15]}}, rshift[15:0]};
            SZ_W:    load_data_o = {{(XLEN-32){sext & rshift[31]}}, rshift[31:0]};
            default: load_data_o = rshift;
        endcase

        mem_addr_o  = {addr_i[XLEN-1:3], 3'b000};
        mem_wdata_o = wsized << shamt;
        mem_wmask_o = size_mask(size) << addr_i[2:0];
        chk_err_o   = (chk_op_i == MEMOP_ILLEGAL) || misaligned(op_size(chk_op_i), chk_off_i);
    end

endmodule

// File: rtl/ysyx_220053_lsu.sv
// Load/store unit: accepts one request, runs a single bus transaction, and
// holds the extended result until the consumer takes it.
module ysyx_220053_lsu
    import ysyx_220053_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_memop,
    input  logic            in_wen,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_err
);

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            wen_q, wen_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            req_err;
    logic [XLEN-1:0] load_data;
    logic [7:0]      lane_mask;

    ysyx_220053_lsu_align #(.XLEN(XLEN)) u_align (
        .op_i        (op_q),
        .addr_i      (addr_q),
        .wdata_i     (wdata_q),
        .rdata_i     (mem_rdata),
        .chk_op_i    (in_memop),
        .chk_off_i   (in_addr[2:0]),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wmask_o (lane_mask),
        .load_data_o (load_data),
        .chk_err_o   (req_err)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_memop;
                    wen_d   = in_wen;
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = req_err ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (mem_ack) begin
                    rdata_d = wen_q ? '0 : load_data;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs decode the state register only, so in_valid never reaches them.
    assign in_ready  = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_BUS);
    assign mem_we    = wen_q;
    assign mem_wmask = mem_req ? lane_mask : 8'h00;
    assign out_valid = (state_q == ST_RESP);
    assign out_rdata = rdata_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_220053_lsu.sv
// Scoreboard bench: each accepted request pushes its expected response, which
// is popped and compared at the out handshake.
module tb_ysyx_220053_lsu;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_memop;
    logic            in_wen;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rdata;
    logic            out_err;

    always #5 clk = ~clk;

    ysyx_220053_lsu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_memop  (in_memop),
        .in_wen    (in_wen),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata (out_rdata),
        .out_err   (out_err)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [2:0]  op;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          waits;
        int          hold;
    } stim_t;

    resp_t       sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        exp_err;
    logic        exp_we;
    logic [63:0] exp_addr;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_mask;

    stim_t tbl [16] = '{
        '{3'b001, 1'b0, 64'h8000_0003, 64'h0,                   64'h0000_0000_80FF_0000, 0, 0}, // lb
        '{3'b010, 1'b1, 64'h8000_0006, 64'h1234,                64'h0,                   0, 1}, // sh
        '{3'b100, 1'b0, 64'h8000_0004, 64'h0,                   64'hDEAD_BEEF_0000_0000, 3, 0}, // lwu
        '{3'b011, 1'b0, 64'h8000_0004, 64'h0,                   64'h0,                   0, 0}, // ld misaligned
        '{3'b111, 1'b0, 64'h8000_0000, 64'h0,                   64'h0,                   0, 0}, // illegal
        '{3'b010, 1'b0, 64'h8000_0002, 64'h0,                   64'h0000_0000_8001_0000, 1, 0}, // lh
        '{3'b110, 1'b0, 64'h8000_0002, 64'h0,                   64'h0000_0000_8001_0000, 0, 2}, // lhu
        '{3'b011, 1'b0, 64'h8000_0008, 64'h0,                   64'h0123_4567_89AB_CDEF, 2, 0}, // ld
        '{3'b000, 1'b0, 64'h8000_0004, 64'h0,                   64'h8765_4321_0000_0000, 0, 0}, // lw
        '{3'b101, 1'b0, 64'h8000_0007, 64'h0,                   64'hF000_0000_0000_0000, 0, 0}, // lbu
        '{3'b011, 1'b1, 64'h8000_0010, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0,                   1, 0}, // sd
        '{3'b001, 1'b1, 64'h8000_0005, 64'hFFEE,                64'h0,                   0, 0}, // sb
        '{3'b000, 1'b1, 64'h8000_0004, 64'h1_CAFE_BABE,         64'h0,                   0, 0}, // sw
        '{3'b010, 1'b0, 64'h8000_0001, 64'h0,                   64'h0,                   0, 0}, // lh misaligned
        '{3'b000, 1'b1, 64'h8000_0002, 64'h5555,                64'h0,                   0, 0}, // sw misaligned
        '{3'b001, 1'b0, 64'h8000_0000, 64'h0,                   64'hFFFF_FFFF_FFFF_FF7F, 0, 0}  // lb positive
    };

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic int op_bytes(input logic [2:0] op);
        case (op[1:0])
            2'b01:   return 1;
            2'b10:   return 2;
            2'b00:   return 4;
            default: return 8;
        endcase
    endfunction

    // Byte-wise reference: pick n bytes starting at the lane offset, then extend.
    function automatic logic [63:0] ref_load(input logic [2:0] op, input logic [2:0] off,
                                             input logic [63:0] d);
        int          n = op_bytes(op);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++)
            if (i < n) v[8*i +: 8] = d[8*((int'(off) + i) % 8) +: 8];
        if (n < 8 && !op[2] && v[8*n-1])
            for (int i = 0; i < 8; i++)
                if (i >= n) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic issue(input logic [2:0] op, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] rdata);
        int          n = op_bytes(op);
        logic [2:0]  off = addr[2:0];
        int          waited = 0;
        resp_t       r;
        in_memop = op;
        in_wen   = wen;
        in_addr  = addr;
        in_wdata = wdata;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        exp_err   = (op == 3'b111) || ((int'(off) % n) != 0);
        exp_we    = wen;
        exp_addr  = addr & ~64'h7;
        exp_mask  = 8'((1 << n) - 1) << off;
        exp_wdata = '0;
        for (int i = 0; i < 8; i++)
            if (i < n) exp_wdata[8*((int'(off) + i) % 8) +: 8] = wdata[8*i +: 8];
        r.err   = exp_err;
        r.rdata = (exp_err || wen) ? 64'h0 : ref_load(op, off, rdata);
        sb_q.push_back(r);
    endtask

    task automatic bus_phase(input int waits, input logic [63:0] rdata);
        if (exp_err) begin
            check("err_no_req", mem_req, 0);
            check("err_valid_c1", out_valid, 1);
            check("err_flag", out_err, 1);
            return;
        end
        mem_rdata = ~rdata;
        for (int c = 0; c <= waits; c++) begin
            check("mem_req", mem_req, 1);
            check("mem_addr", mem_addr, exp_addr);
            check("mem_we", mem_we, exp_we);
            check("mem_wmask", mem_wmask, exp_mask);
            if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            check("early_valid", out_valid, 0);
            if (c == waits) begin
                mem_rdata = rdata;
                mem_ack   = 1'b1;
            end
            @(posedge clk); #1;
        end
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("valid_after_ack", out_valid, 1);
        check("req_drop", mem_req, 0);
    endtask

    task automatic respond(input int hold);
        resp_t r;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
            return;
        end
        r = sb_q.pop_front();
        for (int c = 0; c < hold; c++) begin
            out_ready = 1'b0;
            check("hold_valid", out_valid, 1);
            check("hold_rdata", out_rdata, r.rdata);
            check("hold_err", out_err, r.err);
            check("hold_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("out_valid", out_valid, 1);
        check("out_rdata", out_rdata, r.rdata);
        check("out_err", out_err, r.err);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_memop  = '0;
        in_wen    = 1'b0;
        in_addr   = '0;
        in_wdata  = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_err", out_err, 0);
        check("rst_out_rdata", out_rdata, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_valid", out_valid, 0);

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].rdata);
            bus_phase(tbl[i].waits, tbl[i].rdata);
            respond(tbl[i].hold);
        end

        // A request offered while the response is stalled waits for the cycle after the handshake.
        issue(3'b000, 1'b0, 64'h8000_0000, 64'h0, 64'h0000_0000_1122_3344);
        bus_phase(0, 64'h0000_0000_1122_3344);
        in_memop = 3'b101;
        in_wen   = 1'b0;
        in_addr  = 64'h8000_0001;
        in_wdata = 64'h0;
        in_valid = 1'b1;
        respond(4);
        check("hs_no_accept", mem_req, 0);
        check("hs_ready_next", in_ready, 1);
        issue(3'b101, 1'b0, 64'h8000_0001, 64'h0, 64'h0000_0000_0000_9A00);
        bus_phase(0, 64'h0000_0000_0000_9A00);
        respond(0);

        // Reset mid-transaction drops it; a late ack afterwards is ignored.
        issue(3'b001, 1'b0, 64'h8000_0003, 64'h0, 64'h0);
        check("rst_bus_req", mem_req, 1);
        rst = 1'b1;
        #1;
        check("rst_async_req", mem_req, 0);
        check("rst_async_valid", out_valid, 0);
        check("rst_async_ready", in_ready, 1);
        check("rst_async_wmask", mem_wmask, 0);
        void'(sb_q.pop_back());
        @(posedge clk); #1;
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        check("late_ack_valid", out_valid, 0);
        check("late_ack_req", mem_req, 0);
        check("late_ack_ready", in_ready, 1);
        @(posedge clk); #1;
        check("late_ack_valid2", out_valid, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
